// File: rtl/raster_pkg.sv
// raster_pkg: shared constants and state type for the line rasterizer.
package raster_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    // Input/output coordinate width, internal framebuffer width, error width
    localparam int CW = 10;
    localparam int IW = 12;
    localparam int EW = 13;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        DRAW
    } state_t;

endpackage

// File: rtl/line_setup.sv
// line_setup: centred-to-framebuffer endpoint conversion and Bresenham
// initial terms (dx, dy, step directions, initial error). Purely combinational.
module line_setup #(
    parameter int SCREEN_W = raster_pkg::SCREEN_W,
    parameter int SCREEN_H = raster_pkg::SCREEN_H,
    parameter int CW       = raster_pkg::CW
) (
    input  logic signed [CW-1:0]              x0,
    input  logic signed [CW-1:0]              y0,
    input  logic signed [CW-1:0]              x1,
    input  logic signed [CW-1:0]              y1,
    output logic signed [raster_pkg::IW-1:0]  fx0,
    output logic signed [raster_pkg::IW-1:0]  fy0,
    output logic signed [raster_pkg::IW-1:0]  fx1,
    output logic signed [raster_pkg::IW-1:0]  fy1,
    output logic signed [raster_pkg::IW-1:0]  dx,
    output logic signed [raster_pkg::IW-1:0]  dy,
    output logic                              stx_neg,
    output logic                              sty_neg,
    output logic signed [raster_pkg::EW-1:0]  err0
);
    import raster_pkg::*;

    localparam logic signed [IW-1:0] XOFF = IW'(SCREEN_W / 2);
    localparam logic signed [IW-1:0] YOFF = IW'(SCREEN_H / 2);

    logic signed [IW-1:0] sx0, sy0, sx1, sy1;
    logic signed [IW-1:0] ddx, ddy;

    // Sign-extend, flip y to point down, and derive |dx|, -|dy| and directions
    always_comb begin
        sx0     = $signed({{(IW-CW){x0[CW-1]}}, x0});
        sy0     = $signed({{(IW-CW){y0[CW-1]}}, y0});
        sx1     = $signed({{(IW-CW){x1[CW-1]}}, x1});
        sy1     = $signed({{(IW-CW){y1[CW-1]}}, y1});
        fx0     = sx0 + XOFF;
        fy0     = YOFF - sy0;
        fx1     = sx1 + XOFF;
        fy1     = YOFF - sy1;
        ddx     = fx1 - fx0;
        ddy     = fy1 - fy0;
        stx_neg = ddx[IW-1];
        sty_neg = ddy[IW-1];
        dx      = stx_neg ? -ddx : ddx;
        dy      = sty_neg ? ddy : -ddy;
        err0    = $signed({{(EW-IW){dx[IW-1]}}, dx}) + $signed({{(EW-IW){dy[IW-1]}}, dy});
    end

endmodule

// File: rtl/line_raster.sv
// line_raster: Bresenham line rasterizer emitting one framebuffer pixel per
// cycle over a valid/ready handshake. Define LINE_RASTER_CLIP_EN to step
// off-screen pixels silently instead of presenting them.
module line_raster #(
    parameter int SCREEN_W = raster_pkg::SCREEN_W,
    parameter int SCREEN_H = raster_pkg::SCREEN_H,
    parameter int CW       = raster_pkg::CW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [CW-1:0] x0,
    input  logic signed [CW-1:0] y0,
    input  logic signed [CW-1:0] x1,
    input  logic signed [CW-1:0] y1,
    output logic                 pix_valid,
    input  logic                 pix_ready,
    output logic [CW-1:0]        pix_x,
    output logic [CW-1:0]        pix_y,
    output logic                 busy,
    output logic                 done
);
    import raster_pkg::*;

    localparam logic signed [IW-1:0] PLUS1  = IW'(1);
    localparam logic signed [IW-1:0] MINUS1 = '1;

    state_t state, state_nxt;

    logic signed [CW-1:0] lx0, ly0, lx1, ly1;

    logic signed [IW-1:0] s_x0, s_y0, s_x1, s_y1, s_dx, s_dy;
    logic                 s_stx_neg, s_sty_neg;
    logic signed [EW-1:0] s_err;

    logic signed [IW-1:0] cx, cy, ex, ey, dx, dy;
    logic                 stx_neg, sty_neg;
    logic signed [EW-1:0] err;
    logic                 primed;

    logic                 accept, step, at_end;
    logic signed [EW:0]   e2, dx_w, dy_w;
    logic signed [IW-1:0] nx, ny;
    logic signed [EW-1:0] nerr;
    logic                 vis_cur, vis_nxt;

    line_setup #(
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H),
        .CW       (CW)
    ) u_setup (
        .x0      (lx0),
        .y0      (ly0),
        .x1      (lx1),
        .y1      (ly1),
        .fx0     (s_x0),
        .fy0     (s_y0),
        .fx1     (s_x1),
        .fy1     (s_y1),
        .dx      (s_dx),
        .dy      (s_dy),
        .stx_neg (s_stx_neg),
        .sty_neg (s_sty_neg),
        .err0    (s_err)
    );

    // Handshake qualifiers and the next Bresenham position from the pre-step error
    always_comb begin
        accept = (state == IDLE) && in_valid && in_ready;
        // pix_valid is low only for clipped pixels, which step without a handshake
        step   = (state == DRAW) && primed && (!pix_valid || pix_ready);
        at_end = (cx == ex) && (cy == ey);
        e2     = $signed({err, 1'b0});
        dx_w   = $signed({{(EW+1-IW){dx[IW-1]}}, dx});
        dy_w   = $signed({{(EW+1-IW){dy[IW-1]}}, dy});
        nx     = cx;
        ny     = cy;
        nerr   = err;
        if (e2 >= dy_w) begin
            nerr = nerr + $signed({{(EW-IW){dy[IW-1]}}, dy});
            nx   = cx + (stx_neg ? MINUS1 : PLUS1);
        end
        if (e2 <= dx_w) begin
            nerr = nerr + $signed({{(EW-IW){dx[IW-1]}}, dx});
            ny   = cy + (sty_neg ? MINUS1 : PLUS1);
        end
    end

`ifdef LINE_RASTER_CLIP_EN
    localparam logic signed [IW-1:0] XLIM = IW'(SCREEN_W);
    localparam logic signed [IW-1:0] YLIM = IW'(SCREEN_H);

    // On-screen test for the current and the next pixel
    always_comb begin
        vis_cur = !cx[IW-1] && (cx < XLIM) && !cy[IW-1] && (cy < YLIM);
        vis_nxt = !nx[IW-1] && (nx < XLIM) && !ny[IW-1] && (ny < YLIM);
    end
`else
    // Without clipping every Bresenham pixel is presented
    always_comb begin
        vis_cur = 1'b1;
        vis_nxt = 1'b1;
    end
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode and busy flag
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        case (state)
            IDLE:  if (accept) state_nxt = SETUP;
            SETUP: begin
                busy      = 1'b1;
                state_nxt = DRAW;
            end
            DRAW: begin
                busy = 1'b1;
                if (step && at_end) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: endpoint latch, setup capture, stepping and registered pixel outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready  <= 1'b0;
            done      <= 1'b0;
            pix_valid <= 1'b0;
            pix_x     <= '0;
            pix_y     <= '0;
            primed    <= 1'b0;
            lx0       <= '0;
            ly0       <= '0;
            lx1       <= '0;
            ly1       <= '0;
            cx        <= '0;
            cy        <= '0;
            ex        <= '0;
            ey        <= '0;
            dx        <= '0;
            dy        <= '0;
            stx_neg   <= 1'b0;
            sty_neg   <= 1'b0;
            err       <= '0;
        end else begin
            in_ready <= (state_nxt == IDLE);
            done     <= step && at_end;
            if (accept) begin
                lx0 <= x0;
                ly0 <= y0;
                lx1 <= x1;
                ly1 <= y1;
            end
            case (state)
                SETUP: begin
                    cx        <= s_x0;
                    cy        <= s_y0;
                    ex        <= s_x1;
                    ey        <= s_y1;
                    dx        <= s_dx;
                    dy        <= s_dy;
                    stx_neg   <= s_stx_neg;
                    sty_neg   <= s_sty_neg;
                    err       <= s_err;
                    primed    <= 1'b0;
                    pix_valid <= 1'b0;
                end
                DRAW: begin
                    // First DRAW cycle only loads the output register with the start pixel
                    if (!primed) begin
                        primed    <= 1'b1;
                        pix_valid <= vis_cur;
                        pix_x     <= cx[CW-1:0];
                        pix_y     <= cy[CW-1:0];
                    end else if (step) begin
                        if (at_end) begin
                            primed    <= 1'b0;
                            pix_valid <= 1'b0;
                        end else begin
                            cx        <= nx;
                            cy        <= ny;
                            err       <= nerr;
                            pix_valid <= vis_nxt;
                            pix_x     <= nx[CW-1:0];
                            pix_y     <= ny[CW-1:0];
                        end
                    end
                end
                default: pix_valid <= 1'b0;
            endcase
        end
    end

endmodule

// File: doc/line_raster.md
Name: line_raster

Overview:
- Downstream neighbour of the vertex transform stage. Consumes pairs of projected screen-space endpoints: signed 10-bit, centred origin, +y up.
- Rasterizes the segment between them with integer Bresenham.
- Emits one framebuffer pixel coordinate per cycle over a valid/ready handshake to the pixel writer.
- Converts centred coordinates to framebuffer coordinates (origin top-left, +y down) and clips to the screen.

Parameters:
- SCREEN_W, 640, framebuffer width in pixels; X offset is SCREEN_W/2.
- SCREEN_H, 480, framebuffer height in pixels; Y offset is SCREEN_H/2.
- CW, 10, input coordinate width (signed) and output coordinate width (unsigned).

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  endpoint pair present.
- in_ready  out  1  block idle and able to accept a line.
- x0, y0, x1, y1  in  CW signed  centred screen-space endpoints, sampled on in_valid && in_ready.
- pix_valid  out  1  pix_x/pix_y hold an on-screen pixel.
- pix_ready  in  1  sink accepts the pixel.
- pix_x  out  CW unsigned  framebuffer column.
- pix_y  out  CW unsigned  framebuffer row.
- busy  out  1  line in progress (SETUP or DRAW).
- done  out  1  one-cycle pulse after the last pixel step of a line.

Behaviour:
- Reset (async assert): state=IDLE. in_ready, pix_valid, busy and done are 0; pix_x and pix_y are 0. in_ready is registered and rises on the first clock edge after rst deasserts.
- FSM states: IDLE, SETUP, DRAW.
  - IDLE: in_ready=1. On in_valid && in_ready, latch endpoints, go to SETUP, drop in_ready.
  - SETUP (1 cycle): compute, in 12-bit signed, X=x+SCREEN_W/2 and Y=SCREEN_H/2-y for both endpoints. Then dx=|X1-X0|, dy=-|Y1-Y0|, stx=sign(X1-X0) (±1), sty=sign(Y1-Y0) (±1), err=dx+dy (13-bit signed). Set cur=(X0,Y0). Go to DRAW.
  - DRAW:
    - A step occurs when (pix_valid && pix_ready), or when the current pixel is off-screen (clipped pixels take one cycle, no handshake).
    - On a step where cur==(X1,Y1): pulse done, go to IDLE.
    - Otherwise, with e2=2*err: if e2>=dy then err+=dy and cx+=stx; if e2<=dx then err+=dx and cy+=sty. Both tests use the pre-step err, and both updates may apply in the same step.
- Latency: the endpoint-accept edge is N; pix_valid can first be high in the cycle after edge N+2. With pix_ready held high, throughput is one pixel per cycle. Pixel count is max(dx,-dy)+1, including both endpoints.
- Backpressure: while pix_valid && !pix_ready, pix_x, pix_y and internal state hold. No pixel is skipped or duplicated.
- On-screen test: 0<=cx<SCREEN_W and 0<=cy<SCREEN_H. pix_valid is 1 only in DRAW when on-screen. pix_x and pix_y are the low CW bits of cx and cy.
- busy=1 in SETUP and DRAW. done is asserted in the IDLE cycle following the final step.
- Degenerate line (equal endpoints): exactly one pixel, then done.
- Inputs are ignored while busy; in_valid may stay high.
- Reset mid-line: async abort; pix_valid drops immediately and no done pulse is produced.

Optional Feature:
- Macro: LINE_RASTER_CLIP_EN.
- Defined: clipping as described above; off-screen pixels are stepped silently.
- Undefined: no on-screen test. Every Bresenham pixel is presented with pix_valid and waits for pix_ready, and pix_x/pix_y carry the truncated low CW bits. The sink is responsible for discarding out-of-range coordinates.

Decomposition:
- Shared package raster_pkg:
  - SCREEN_W and SCREEN_H defaults.
  - Coordinate width constants: CW=10, internal IW=12, error EW=13.
  - State enum typedef {IDLE, SETUP, DRAW}.
- One natural sub-module, line_setup: combinational centred-to-framebuffer conversion plus dx/dy/stx/sty/err0, registered by the parent in SETUP.

Test Plan:
- Horizontal: (0,0)->(3,0), pix_ready=1 -> pixels (320,240),(321,240),(322,240),(323,240) on consecutive cycles, then done pulse, in_ready=1.
- Steep, +y up: (0,0)->(1,3) -> (320,240),(320,239),(321,238),(321,237), exactly 4 pixels.
- Degenerate: (5,5)->(5,5) -> single pixel (325,235), then done.
- Backpressure: (0,0)->(3,0) with pix_ready low for 3 cycles while (321,240) is presented -> coordinates stable throughout, sequence unchanged, 4 accepted pixels total.
- Clip: (315,0)->(325,0).
  - LINE_RASTER_CLIP_EN defined: only (635..639,240) are emitted (5 pixels), and done follows 11 steps.
  - Undefined: 11 pixels are emitted.
- Reset mid-line: assert rst during pixel 2 of (0,0)->(3,0) -> pix_valid=0 immediately and no done. After release, in_ready rises next edge, and a new line (0,0)->(0,1) yields (320,240),(320,239).
